// File: rtl/inference_sequencer_pkg.sv
// Shared types and constants for the MNIST inference sequencer.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAT,
    S_L1,
    S_L2,
    S_ARGMAX,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_PIXCNT  = 3'd1,
    ERR_TO_FLAT = 3'd2,
    ERR_TO_L1   = 3'd3,
    ERR_TO_L2   = 3'd4,
    ERR_TO_AM   = 3'd5
  } err_code_t;

  localparam int unsigned N_PIXELS_MNIST = 784;
  localparam int unsigned NUM_CLASSES    = 10;
  localparam int unsigned PIX_W          = 10;

  function automatic logic is_busy(input state_t s);
    return (s == S_FLAT) || (s == S_L1) || (s == S_L2) || (s == S_ARGMAX);
  endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Start/done handshake bundle between the sequencer and its datapath stages.
interface inference_sequencer_if;
  logic       flat_start;
  logic       flat_valid;
  logic       flat_done;
  logic       l1_start;
  logic       l1_done;
  logic       l2_start;
  logic       l2_done;
  logic       am_start;
  logic       am_done;
  logic [3:0] am_class;

  modport master (
    output flat_start, l1_start, l2_start, am_start,
    input  flat_valid, flat_done, l1_done, l2_done, am_done, am_class
  );

  modport slave (
    input  flat_start, l1_start, l2_start, am_start,
    output flat_valid, flat_done, l1_done, l2_done, am_done, am_class
  );
endinterface

// File: rtl/inference_sequencer_stage_watchdog.sv
// Per-stage cycle watchdog: expires on the TIMEOUT-th running cycle since clear.
module stage_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (clear)            r_cnt <= '0;
    else if (run && !expired)  r_cnt <= r_cnt + CW'(1);
  end

  assign expired = run && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/inference_sequencer.sv
// Schedules flatten -> dense1 -> dense2 -> argmax for one inference, with pixel-count and watchdog checks.
module inference_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned N_PIXELS = 784,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned CYC_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       class_out,
  output logic [CYC_W-1:0] cycles,
  output logic             err,
  output logic [2:0]       err_code,
  inference_sequencer_if.master stg
);
  state_t           r_state, w_next;
  logic             r_entry;
  logic [PIX_W-1:0] r_pix, w_pix;
  logic [3:0]       r_class;
  logic [CYC_W-1:0] r_cycles;
  err_code_t        r_code, w_code, w_to_code;
  logic             w_accept, w_busy, w_stage_done, w_expired;

  assign w_busy = is_busy(r_state);

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_next != r_state),
    .run     (w_busy),
    .expired (w_expired)
  );

  always_comb begin
    w_next       = r_state;
    w_code       = r_code;
    w_accept     = 1'b0;
    w_stage_done = 1'b0;
    w_to_code    = ERR_NONE;
    w_pix        = r_pix;
    // The beat coincident with flat_done is folded into the count being checked.
    if (r_state == S_FLAT && stg.flat_valid && r_pix != '1) w_pix = r_pix + PIX_W'(1);
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_next   = S_FLAT;
          w_accept = 1'b1;
          w_code   = ERR_NONE;
        end
      end
      S_FLAT: begin
        w_stage_done = stg.flat_done;
        w_to_code    = ERR_TO_FLAT;
        if (stg.flat_done) begin
          if (w_pix == PIX_W'(N_PIXELS)) w_next = S_L1;
          else begin
            w_next = S_ERR;
            w_code = ERR_PIXCNT;
          end
        end
      end
      S_L1: begin
        w_stage_done = stg.l1_done;
        w_to_code    = ERR_TO_L1;
        if (stg.l1_done) w_next = S_L2;
      end
      S_L2: begin
        w_stage_done = stg.l2_done;
        w_to_code    = ERR_TO_L2;
        if (stg.l2_done) w_next = S_ARGMAX;
      end
      S_ARGMAX: begin
        w_stage_done = stg.am_done;
        w_to_code    = ERR_TO_AM;
        if (stg.am_done) w_next = S_DONE;
      end
      default: ;
    endcase
    if (w_busy && !w_stage_done && w_expired) begin
      w_next = S_ERR;
      w_code = w_to_code;
    end
    if (w_busy && abort) begin
      w_next = S_IDLE;
      w_code = r_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_entry  <= 1'b0;
      r_pix    <= '0;
      r_class  <= '0;
      r_cycles <= '0;
      r_code   <= ERR_NONE;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      r_code  <= w_code;
      if (w_accept) begin
        r_pix    <= '0;
        r_class  <= '0;
        r_cycles <= '0;
      end else begin
        if (r_state == S_FLAT) r_pix <= w_pix;
        if (w_busy) r_cycles <= r_cycles + CYC_W'(1);
        if (r_state == S_ARGMAX && w_next == S_DONE) r_class <= stg.am_class;
      end
    end
  end

  assign busy           = w_busy;
  assign done           = (r_state == S_DONE) && r_entry;
  assign err            = (r_state == S_ERR);
  assign err_code       = r_code;
  assign class_out      = r_class;
  assign cycles         = r_cycles;
  assign stg.flat_start = (r_state == S_FLAT)   && r_entry;
  assign stg.l1_start   = (r_state == S_L1)     && r_entry;
  assign stg.l2_start   = (r_state == S_L2)     && r_entry;
  assign stg.am_start   = (r_state == S_ARGMAX) && r_entry;
endmodule
